// File: rtl/bus_arbiter_4_32_if.sv
// Request/grant and data bundle between four requesters,
// the arbiter and a single downstream consumer.
interface bus_arbiter_4_32_if;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] src3;
    logic        out_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    modport master (
        output req, last,
        output src0, src1, src2, src3,
        output out_ready,
        input  gnt, sel, out_valid,
        input  out_data, busy
    );

    modport slave (
        input  req, last,
        input  src0, src1, src2, src3,
        input  out_ready,
        output gnt, sel, out_valid,
        output out_data, busy
    );
endinterface

// File: rtl/bus_arbiter_4_32.sv
// Four-way round-robin bus arbiter with per-tenure beat limit,
// registered one-hot grant and gated 32-bit data mux.
module bus_arbiter_4_32 #(
    parameter int MAX_BEATS = 16
) (
    input logic             clk,
    input logic             resetn,
    bus_arbiter_4_32_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        found;
    logic        own_req;
    logic        valid;
    logic        accept;
    logic        at_max;

    // Rotating priority search starting at ptr
    always_comb begin
        pick  = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign own_req = bus.req[sel_q];
    assign valid   = (state_q == GRANT) && own_req;
    assign accept  = valid && bus.out_ready;
    assign at_max  = ({1'b0, cnt_q} + 5'd1) == 5'(MAX_BEATS);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!own_req
                    || (accept && (bus.last[sel_q] || at_max))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + 2'd1;
                end else if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-hot AND-OR mux; gnt_q always matches sel_q in GRANT
    assign bus.out_data = {32{valid}} & (
          ({32{gnt_q[0]}} & bus.src0)
        | ({32{gnt_q[1]}} & bus.src1)
        | ({32{gnt_q[2]}} & bus.src2)
        | ({32{gnt_q[3]}} & bus.src3));

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid;
    assign bus.busy      = (state_q == GRANT);
endmodule

// File: tb/tb_bus_arbiter_4_32.sv
// Directed bench for bus_arbiter_4_32: rotation, beat limit,
// stall, abandon and mid-tenure reset.
module tb_bus_arbiter_4_32;
    logic clk;
    logic resetn;
    int   tests;
    int   fails;
    logic [31:0] sv [4];

    bus_arbiter_4_32_if bus ();

    bus_arbiter_4_32 #(.MAX_BEATS(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sv[0] = 32'hA0A0_0000;
        sv[1] = 32'hB1B1_1111;
        sv[2] = 32'hC2C2_2222;
        sv[3] = 32'hD3D3_3333;
        bus.src0 = sv[0];
        bus.src1 = sv[1];
        bus.src2 = sv[2];
        bus.src3 = sv[3];
        bus.req = '0;
        bus.last = '0;
        bus.out_ready = 1'b1;
        resetn = 1'b0;
        #1;
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_data", bus.out_data, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // first grant from ptr=0 goes to requester 1
        bus.req = 4'b1010;
        bus.out_ready = 1'b0;
        #1;
        check("lat_gnt0", 32'(bus.gnt), 0);
        tick();
        check("g1_gnt", 32'(bus.gnt), 32'h2);
        check("g1_sel", 32'(bus.sel), 1);
        check("g1_busy", 32'(bus.busy), 1);

        // three beats, last on the third
        bus.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.last = (b == 2) ? 4'b0010 : 4'b0000;
            #1;
            check("b_valid", 32'(bus.out_valid), 1);
            check("b_data", bus.out_data, sv[1]);
            tick();
        end
        bus.last = '0;
        #1;
        check("bub_gnt", 32'(bus.gnt), 0);
        check("bub_valid", 32'(bus.out_valid), 0);
        check("bub_data", bus.out_data, 0);
        check("bub_busy", 32'(bus.busy), 0);
        tick();
        check("g3_gnt", 32'(bus.gnt), 32'h8);
        check("g3_sel", 32'(bus.sel), 3);

        // abandon: owner drops req
        bus.req = 4'b0000;
        #1;
        check("ab_valid", 32'(bus.out_valid), 0);
        check("ab_data", bus.out_data, 0);
        tick();
        check("ab_gnt", 32'(bus.gnt), 0);

        // full rotation with all requesting
        bus.req = 4'b1111;
        bus.last = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rot_gnt", 32'(bus.gnt),
                  32'(4'b0001 << (k % 4)));
            check("rot_data", bus.out_data, sv[k % 4]);
            if (k == 4) begin
                bus.req = 4'b0100;
                bus.last = 4'b0000;
            end
            tick();
            check("rot_bub", 32'(bus.gnt), 0);
        end

        // requester 2 streams, forced release after 16
        tick();
        check("s2_gnt", 32'(bus.gnt), 32'h4);
        for (int b = 0; b < 16; b++) begin
            check("s2_hold", 32'(bus.gnt), 32'h4);
            check("s2_data", bus.out_data, sv[2]);
            tick();
        end
        check("s2_rel", 32'(bus.gnt), 0);
        check("s2_busy", 32'(bus.busy), 0);
        bus.req = 4'b1100;
        tick();
        check("s2_ptr3", 32'(bus.gnt), 32'h8);
        bus.req = 4'b0000;
        tick();
        check("s2_idle", 32'(bus.gnt), 0);

        // stall: out_ready low keeps count at 0
        bus.req = 4'b0001;
        bus.out_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            check("st_valid", 32'(bus.out_valid), 1);
            check("st_gnt", 32'(bus.gnt), 32'h1);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            check("st_hold", 32'(bus.gnt), 32'h1);
            tick();
        end
        check("st_rel", 32'(bus.gnt), 0);

        // reset during beat 2 of requester 2
        bus.req = 4'b0100;
        tick();
        check("r2_gnt", 32'(bus.gnt), 32'h4);
        tick();
        check("r2_beat2", 32'(bus.out_valid), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("mr_gnt", 32'(bus.gnt), 0);
        check("mr_valid", 32'(bus.out_valid), 0);
        check("mr_data", bus.out_data, 0);
        check("mr_sel", 32'(bus.sel), 0);
        check("mr_busy", 32'(bus.busy), 0);
        bus.req = 4'b0101;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("mr_regnt", 32'(bus.gnt), 32'h1);
        check("mr_resel", 32'(bus.sel), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
